// File: rtl/la_clk_pkg.sv
// Shared definitions for the PLL-lock / sample-clock logic: lock FSM states
// and default sizing for the strobe generator.
package la_clk_pkg;

    localparam int         LA_DW            = 8;
    localparam logic [7:0] LA_DEF_DECIM     = 8'd7;
    localparam int         LA_SETTLE_CYCLES = 16;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } lock_state_t;

endpackage

// File: rtl/lock_sync2.sv
// Two-flop level synchronizer with synchronous active-high reset; brings an
// asynchronous level such as a PLL lock flag into the clk domain.
module lock_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic async_lvl,
    output logic sync_lvl
);

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= async_lvl;
            sync_p1 <= sync_p0;
        end
    end

    assign sync_lvl = sync_p1;

endmodule

// File: rtl/sample_strobe_gen.sv
// Sample-enable strobe generator on the 8x PLL clock, gated by synchronized lock.
// Optional STROBE_COUNT_EN adds a 16-bit wrapping strobe counter (strb_cnt).
module sample_strobe_gen
    import la_clk_pkg::*;
#(
    parameter int            DW            = LA_DW,
    parameter logic [DW-1:0] DEF_DECIM     = DW'(LA_DEF_DECIM),
    parameter int            SETTLE_CYCLES = LA_SETTLE_CYCLES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          locked,
    input  logic [DW-1:0] cfg_decim,
    input  logic          cfg_vld,
    output logic          cfg_rdy,
    output logic          smpl_en,
    output logic          pll_ok,
    output logic [DW-1:0] cur_decim
`ifdef STROBE_COUNT_EN
    ,
    output logic [15:0]   strb_cnt
`endif
);

    localparam int            SW          = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    lock_state_t   state;
    lock_state_t   state_nxt;
    logic          lock_s;
    logic [DW-1:0] dcnt;
    logic [DW-1:0] dcnt_nxt;
    logic [SW-1:0] scnt;
    logic [SW-1:0] scnt_nxt;
    logic          pend;
    logic [DW-1:0] pend_val;
    logic          reload;

    lock_sync2 u_lock_sync (
        .clk       (clk),
        .rst       (rst),
        .async_lvl (locked),
        .sync_lvl  (lock_s)
    );

    // Strobe is qualified with lock_s so it drops in the very cycle lock is lost
    assign reload  = (state == RUN) && lock_s && (dcnt == '0);
    assign smpl_en = reload;
    assign pll_ok  = (state == RUN);
    assign cfg_rdy = !pend;

    always_comb begin
        state_nxt = state;
        scnt_nxt  = scnt;
        dcnt_nxt  = dcnt;
        case (state)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = SETTLE;
                    scnt_nxt  = '0;
                end
            end
            SETTLE: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    scnt_nxt  = '0;
                    dcnt_nxt  = '0;
                end else if (scnt == SETTLE_LAST) begin
                    state_nxt = RUN;
                    dcnt_nxt  = '0;
                end else begin
                    scnt_nxt = sat_inc(scnt);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    scnt_nxt  = '0;
                    dcnt_nxt  = '0;
                end else if (dcnt == '0) begin
                    dcnt_nxt = pend ? pend_val : cur_decim;
                end else begin
                    dcnt_nxt = dcnt - 1'b1;
                end
            end
            default: state_nxt = WAIT_LOCK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_LOCK;
            scnt  <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_nxt;
            scnt  <= scnt_nxt;
            dcnt  <= dcnt_nxt;
        end
    end

    // A new value waits for a reload while running, so a period is never cut short
    always_ff @(posedge clk) begin
        if (rst) begin
            pend      <= 1'b0;
            cur_decim <= DEF_DECIM;
        end else if (cfg_vld && !pend) begin
            pend <= 1'b1;
        end else if (pend && ((state != RUN) || reload)) begin
            pend      <= 1'b0;
            cur_decim <= pend_val;
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_vld && !pend) begin
            pend_val <= cfg_decim;
        end
    end

`ifdef STROBE_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            strb_cnt <= '0;
        end else if ((state == RUN) && !lock_s) begin
            strb_cnt <= '0;
        end else if (smpl_en) begin
            strb_cnt <= strb_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sample_strobe_gen.sv
// Scoreboard bench for sample_strobe_gen: expected strobe cycles are queued by
// the stimulus process and matched by a negedge monitor against smpl_en.
module tb_sample_strobe_gen;

    logic       clk;
    logic       rst;
    logic       locked;
    logic [7:0] cfg_decim;
    logic       cfg_vld;
    logic       cfg_rdy;
    logic       smpl_en;
    logic       pll_ok;
    logic [7:0] cur_decim;
`ifdef STROBE_COUNT_EN
    logic [15:0] strb_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_q[$];

    sample_strobe_gen dut (
        .clk       (clk),
        .rst       (rst),
        .locked    (locked),
        .cfg_decim (cfg_decim),
        .cfg_vld   (cfg_vld),
        .cfg_rdy   (cfg_rdy),
        .smpl_en   (smpl_en),
        .pll_ok    (pll_ok),
        .cur_decim (cur_decim)
`ifdef STROBE_COUNT_EN
        ,
        .strb_cnt  (strb_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual %0d required %0d", name, cyc, act, req);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_run(input int first, input int period, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(first + i * period);
    endtask

    // Monitor: every strobe must match the head of the queue in cycle number
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0] < cyc) begin
            checks++;
            errors++;
            $display("FAIL strobe_missed: actual none required strobe at cycle %0d", exp_q[0]);
            void'(exp_q.pop_front());
        end
        if (smpl_en === 1'b1) begin
            checks++;
            if (exp_q.size() > 0 && exp_q[0] == cyc) begin
                void'(exp_q.pop_front());
            end else begin
                errors++;
                $display("FAIL strobe_unexpected: actual strobe at cycle %0d required next at %0d",
                         cyc, (exp_q.size() > 0) ? exp_q[0] : -1);
            end
        end
    end

    initial begin
        int b, r, s, h;
        rst       = 1'b1;
        locked    = 1'b0;
        cfg_vld   = 1'b0;
        cfg_decim = 8'd0;

        wait_cyc(3);
        check("rst_smpl_en", int'(smpl_en), 0);
        check("rst_pll_ok", int'(pll_ok), 0);
        check("rst_cfg_rdy", int'(cfg_rdy), 1);
        check("rst_cur_decim", int'(cur_decim), 7);
`ifdef STROBE_COUNT_EN
        check("rst_strb_cnt", int'(strb_cnt), 0);
`endif
        rst = 1'b0;

        // Lock acquisition with defaults
        b = 5;
        wait_cyc(b);
        push_run(b + 19, 8, 4);
        locked = 1'b1;
        wait_cyc(b + 18);
        check("pll_ok_before_run", int'(pll_ok), 0);
        wait_cyc(b + 19);
        check("pll_ok_first_run", int'(pll_ok), 1);

        // Lock lost so that lock_s falls exactly on a would-be strobe cycle
        wait_cyc(b + 49);
        locked = 1'b0;
        wait_cyc(b + 51);
        check("pll_ok_lock_s_fall", int'(pll_ok), 1);
        wait_cyc(b + 52);
        check("pll_ok_dropped", int'(pll_ok), 0);

        r = b + 60;
        wait_cyc(r);
        push_run(r + 19, 8, 3);
        locked = 1'b1;

        // Decimation change to 3 mid-period
        wait_cyc(r + 29);
        cfg_decim = 8'd3;
        cfg_vld   = 1'b1;
        wait_cyc(r + 30);
        cfg_vld = 1'b0;
        check("cfg_rdy_after_xfer3", int'(cfg_rdy), 0);
        push_run(r + 39, 4, 3);
        wait_cyc(r + 35);
        check("cur_decim_before_apply3", int'(cur_decim), 7);
        wait_cyc(r + 36);
        check("cur_decim_apply3", int'(cur_decim), 3);
        check("cfg_rdy_apply3", int'(cfg_rdy), 1);

        // Back to 7
        wait_cyc(r + 44);
        cfg_decim = 8'd7;
        cfg_vld   = 1'b1;
        wait_cyc(r + 45);
        cfg_vld = 1'b0;
        push_run(r + 55, 8, 2);
        wait_cyc(r + 48);
        check("cur_decim_apply7", int'(cur_decim), 7);

        // Transfer of N=0 on the edge closing a strobe cycle
        wait_cyc(r + 63);
        cfg_decim = 8'd0;
        cfg_vld   = 1'b1;
        wait_cyc(r + 64);
        cfg_vld = 1'b0;
        check("cfg_rdy_after_xfer0", int'(cfg_rdy), 0);
        push_run(r + 71, 1, 10);
        wait_cyc(r + 71);
        check("cur_decim_before_apply0", int'(cur_decim), 7);
        wait_cyc(r + 72);
        check("cur_decim_apply0", int'(cur_decim), 0);
        check("cfg_rdy_apply0", int'(cfg_rdy), 1);
        wait_cyc(r + 79);
        locked = 1'b0;
        wait_cyc(r + 82);
        check("pll_ok_after_drop_n0", int'(pll_ok), 0);

        // One-clock lock glitch during SETTLE restarts the settle interval
        s = r + 90;
        wait_cyc(s);
        locked = 1'b1;
        wait_cyc(s + 8);
        locked = 1'b0;
        wait_cyc(s + 9);
        locked = 1'b1;
        push_run(s + 28, 1, 5);
        wait_cyc(s + 27);
        check("pll_ok_glitch_settle", int'(pll_ok), 0);
        wait_cyc(s + 28);
        check("pll_ok_glitch_run", int'(pll_ok), 1);
        wait_cyc(s + 31);
        locked = 1'b0;

        // Config applied outside RUN, then reset with a config pending
        h = s + 40;
        wait_cyc(h);
        locked = 1'b1;
        wait_cyc(h + 5);
        cfg_decim = 8'd5;
        cfg_vld   = 1'b1;
        wait_cyc(h + 6);
        cfg_vld = 1'b0;
        check("cfg_rdy_idle_xfer", int'(cfg_rdy), 0);
        wait_cyc(h + 7);
        check("cur_decim_idle_apply", int'(cur_decim), 5);
        check("cfg_rdy_idle_apply", int'(cfg_rdy), 1);
        push_run(h + 19, 6, 3);
        wait_cyc(h + 33);
        cfg_decim = 8'd2;
        cfg_vld   = 1'b1;
        wait_cyc(h + 34);
        cfg_vld = 1'b0;
        check("cfg_rdy_before_rst", int'(cfg_rdy), 0);
        wait_cyc(h + 35);
        rst    = 1'b1;
        locked = 1'b0;
        wait_cyc(h + 36);
        check("midrst_pll_ok", int'(pll_ok), 0);
        check("midrst_cfg_rdy", int'(cfg_rdy), 1);
        check("midrst_cur_decim", int'(cur_decim), 7);
        wait_cyc(h + 37);
        rst = 1'b0;
        wait_cyc(h + 38);
        check("midrst_pending_discarded", int'(cur_decim), 7);

`ifdef STROBE_COUNT_EN
        begin
            int g;
            g = h + 45;
            wait_cyc(g);
            locked = 1'b1;
            wait_cyc(g + 2);
            cfg_decim = 8'd0;
            cfg_vld   = 1'b1;
            wait_cyc(g + 3);
            cfg_vld = 1'b0;
            push_run(g + 19, 1, 70000);
            wait_cyc(g + 70017);
            locked = 1'b0;
            wait_cyc(g + 70019);
            check("strb_cnt_wrapped", int'(strb_cnt), 4464);
            wait_cyc(g + 70020);
            check("strb_cnt_cleared", int'(strb_cnt), 0);
        end
`endif

        wait_cyc(cyc + 5);
        check("strobe_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
